// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory access unit.
//   memDst_t : address-source encodings carried on mem_dst
//   state_t  : transaction FSM state (IDLE -> ACCESS -> DONE -> IDLE)
package mem_pkg;

  typedef enum logic [2:0] {
    DST_PC     = 3'b000,  // pc
    DST_IMM    = 3'b001,  // imm
    DST_MARY   = 3'b010,  // mary
    DST_SHEL   = 3'b011,  // shelley
    DST_SP     = 3'b100,  // sp + SP_OFFSET
    DST_IMM_SP = 3'b101   // (imm << 2) + sp ; 110/111 are reserved no-ops
  } memDst_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH x DATA_W synchronous single-port RAM, no reset.
// Ports:
//   clock  - rising-edge clock
//   en     - access enable for this cycle
//   we     - write when en=1, read otherwise
//   addr   - word index
//   wdata  - write data
//   rdata  - registered read data, valid the cycle after a read
module mem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-transaction memory access engine.
// A start seen in IDLE latches a byte address (chosen by mem_dst), the write
// flag, the inst_capture flag and wdata, spends WAIT_STATES+1 cycles in ACCESS
// (RAM access on the last one), then pulses done for one cycle in DONE.
// Read data lands in inst_out or mem_out on the edge that closes DONE.
// Handshake: start is a request sampled only when state is IDLE; while busy=1
// start is ignored; done is a one-cycle completion pulse during DONE, and a
// new start is accepted in the IDLE cycle following it.
// Ports:
//   clock, reset          - clock, synchronous active-high reset
//   start                 - transaction request
//   mem_dst               - address source select (mem_pkg::memDst_t)
//   mem_write             - 1 = write wdata, 0 = read
//   inst_capture          - route read data to inst_out instead of mem_out
//   pc, imm, mary, shelley, sp, wdata - address operands and write data
//   busy, done            - in flight / completion pulse
//   inst_out, mem_out     - registered read results
//   addr_err              - sticky odd-address flag (only with MEM_ALIGN_CHECK_EN)
//   stateDbg              - current FSM state for observation
// Macro MEM_ALIGN_CHECK_EN: enables odd-address detection; an odd address
// skips the RAM access and sets addr_err. Without it, address bit0 is ignored.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1,
  parameter int SP_OFFSET   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        mem_dst,
  input  logic              mem_write,
  input  logic              inst_capture,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] mary,
  input  logic [DATA_W-1:0] shelley,
  input  logic [DATA_W-1:0] sp,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] inst_out,
  output logic [DATA_W-1:0] mem_out,
`ifdef MEM_ALIGN_CHECK_EN
  output logic              addr_err,
`endif
  output state_t            stateDbg
);

  localparam int AW = $clog2(DEPTH);

  state_t            state, stateNext;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] addrNext;
  logic              dstValid;
  logic              accessOk;
  logic [AW-1:0]     idxQ;
  logic              writeQ, instQ, accessQ;
  logic [DATA_W-1:0] wdataQ;
  logic              ramEn, ramWe;
  logic [DATA_W-1:0] rdata;
  logic              unusedAddrBits;

  // Byte address; sums wrap at DATA_W bits.
  always_comb begin
    addrNext = '0;
    dstValid = 1'b1;
    case (mem_dst)
      DST_PC:     addrNext = pc;
      DST_IMM:    addrNext = imm;
      DST_MARY:   addrNext = mary;
      DST_SHEL:   addrNext = shelley;
      DST_SP:     addrNext = sp + DATA_W'(SP_OFFSET);
      DST_IMM_SP: addrNext = (imm << 2) + sp;
      default:    dstValid = 1'b0;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign accessOk = dstValid & ~addrNext[0];
`else
  assign accessOk = dstValid;
`endif

  // Only bits [AW:1] form the word index; the rest alias away.
  assign unusedAddrBits = ^{addrNext[DATA_W-1:AW+1], addrNext[0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      inst_out <= '0;
      mem_out  <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      addr_err <= 1'b0;
`endif
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (start) begin
            idxQ    <= addrNext[AW:1];
            writeQ  <= mem_write;
            instQ   <= inst_capture;
            wdataQ  <= wdata;
            accessQ <= accessOk;
            cnt     <= 4'(WAIT_STATES);
`ifdef MEM_ALIGN_CHECK_EN
            if (dstValid && addrNext[0]) begin
              addr_err <= 1'b1;
            end
`endif
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (accessQ && !writeQ) begin
            if (instQ) begin
              inst_out <= rdata;
            end else begin
              mem_out <= rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    ramEn     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = ACCESS;
        end
      end
      ACCESS: begin
        busy = 1'b1;
        if (cnt == 4'd0) begin
          stateNext = DONE;
          // A reset landing on the access edge aborts the write.
          ramEn = accessQ & ~reset;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign ramWe    = ramEn & writeQ;
  assign stateDbg = state;

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem_array (
    .clock (clock),
    .en    (ramEn),
    .we    (ramWe),
    .addr  (idxQ),
    .wdata (wdataQ),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int W  = 16;
  localparam int WS = 1;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   mem_dst = '0;
  logic         mem_write = 1'b0;
  logic         inst_capture = 1'b0;
  logic [W-1:0] pc = '0, imm = '0, mary = '0, shelley = '0, sp = '0, wdata = '0;
  logic         busy, done;
  logic [W-1:0] inst_out, mem_out;
  state_t       stateDbg;
`ifdef MEM_ALIGN_CHECK_EN
  logic         addr_err;
  localparam logic [W-1:0] EXP9 = 16'h5A5A;
`else
  localparam logic [W-1:0] EXP9 = 16'h1111;
`endif

  int checks = 0;
  int failures = 0;
  logic errExp = 1'b0;

  mem_access_unit #(
    .DATA_W(W), .DEPTH(1024), .WAIT_STATES(WS), .SP_OFFSET(2)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .mem_dst(mem_dst),
    .mem_write(mem_write), .inst_capture(inst_capture),
    .pc(pc), .imm(imm), .mary(mary), .shelley(shelley), .sp(sp), .wdata(wdata),
    .busy(busy), .done(done), .inst_out(inst_out), .mem_out(mem_out),
`ifdef MEM_ALIGN_CHECK_EN
    .addr_err(addr_err),
`endif
    .stateDbg(stateDbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]   dst;
    logic         wr;
    logic         ic;
    logic [W-1:0] pcv, immv, maryv, shelv, spv, wd;
    logic [W-1:0] expMem, expInst;
    logic         odd;
  } rec_t;

  rec_t vec [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one transaction, scramble inputs after latch, wait for done.
  task automatic run_txn(input rec_t r, input string tag);
    int cyc;
    mem_dst = r.dst; mem_write = r.wr; inst_capture = r.ic;
    pc = r.pcv; imm = r.immv; mary = r.maryv; shelley = r.shelv; sp = r.spv; wdata = r.wd;
    start = 1'b1;
    tick();
    start = 1'b0;
    mem_dst = 3'($urandom); mem_write = 1'($urandom); inst_capture = 1'($urandom);
    pc = 16'($urandom); imm = 16'($urandom); mary = 16'($urandom);
    shelley = 16'($urandom); sp = 16'($urandom); wdata = 16'($urandom);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    cyc = 1;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(WS + 2));
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dn;
    logic prevDone;
    rec_t r;

    vec = '{
      '{3'b010, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 1'b0},
      '{3'b010, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 1'b0},
      '{3'b000, 1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'hBEEF, 16'h0000, 1'b0},
      '{3'b001, 1'b0, 1'b0, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 1'b0},
      '{3'b101, 1'b1, 1'b0, 16'h0000, 16'h0003, 16'h0000, 16'h0000, 16'h0100, 16'hCAFE, 16'h1234, 16'h0000, 1'b0},
      '{3'b011, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h010C, 16'h0000, 16'h0000, 16'h1234, 16'hCAFE, 1'b0},
      '{3'b100, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFE, 16'h5A5A, 16'h1234, 16'hCAFE, 1'b0},
      '{3'b000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h5A5A, 16'hCAFE, 1'b0},
      '{3'b100, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h1111, 16'h5A5A, 16'hCAFE, 1'b1},
      '{3'b000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, EXP9,     16'hCAFE, 1'b0},
      '{3'b000, 1'b1, 1'b0, 16'h0800, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h2222, EXP9,     16'hCAFE, 1'b0},
      '{3'b000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h2222, 16'hCAFE, 1'b0},
      '{3'b111, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hDEAD, 16'h2222, 16'hCAFE, 1'b0},
      '{3'b000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h2222, 16'hCAFE, 1'b0},
      '{3'b110, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'h2222, 16'hCAFE, 1'b0},
      '{3'b101, 1'b0, 1'b0, 16'h0000, 16'h0003, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'hCAFE, 16'hCAFE, 1'b0},
      '{3'b010, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0020, 16'h0000, 16'h0000, 16'h3333, 16'hCAFE, 16'hCAFE, 1'b0},
      '{3'b010, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 16'hCAFE, 16'h3333, 1'b0}
    };

    // reset
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_state", 32'(stateDbg), 32'(IDLE));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_out", 32'(mem_out), 32'd0);
    chk("rst_inst_out", 32'(inst_out), 32'd0);

    // table-driven vectors
    for (int i = 0; i < 18; i++) begin
      run_txn(vec[i], $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_mem_out", i), 32'(mem_out), 32'(vec[i].expMem));
      chk($sformatf("vec%0d_inst_out", i), 32'(inst_out), 32'(vec[i].expInst));
      errExp = errExp | vec[i].odd;
`ifdef MEM_ALIGN_CHECK_EN
      chk($sformatf("vec%0d_addr_err", i), 32'(addr_err), 32'(errExp));
`endif
    end

    // start held high every cycle: one transaction per IDLE entry
    mem_dst = 3'b010; mem_write = 1'b0; inst_capture = 1'b0; mary = 16'h0010;
    start = 1'b1;
    dn = 0;
    prevDone = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done) dn++;
      if (done && prevDone) chk("burst_done_twice", 32'd1, 32'd0);
      prevDone = done;
    end
    start = 1'b0;
    chk("burst_done_count", 32'(dn), 32'd3);
    chk("burst_mem_out", 32'(mem_out), 32'hBEEF);

    // reset mid-ACCESS on a write to 0x0020
    mem_dst = 3'b010; mem_write = 1'b1; mary = 16'h0020; wdata = 16'h7777;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_in_access", 32'(stateDbg), 32'(ACCESS));
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    errExp = 1'b0;
    chk("abort_state", 32'(stateDbg), 32'(IDLE));
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_mem_out", 32'(mem_out), 32'd0);
    chk("abort_inst_out", 32'(inst_out), 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("abort_addr_err", 32'(addr_err), 32'd0);
`endif
    tick();
    r = '{3'b010, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0020, 16'h0000, 16'h0000,
          16'h0000, 16'h3333, 16'h0000, 1'b0};
    run_txn(r, "after_abort");
    chk("after_abort_mem_out", 32'(mem_out), 32'h3333);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16: data and address width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024: memory depth in DATA_W words, power of two.
REQ-003 SHALL have parameter WAIT_STATES, default 1, range 0..15: extra access cycles per transaction.
REQ-004 SHALL have parameter SP_OFFSET, default 2: byte offset added to sp for source 100.
REQ-005 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have port start, input, 1: transaction request, sampled only in IDLE.
REQ-008 SHALL have port mem_dst, input, 3: address source select.
REQ-009 SHALL have ports mem_write and inst_capture, inputs, 1 each: write enable; route read data to inst_out instead of mem_out.
REQ-010 SHALL have ports pc, imm, mary, shelley, sp and wdata, inputs, DATA_W each: address operands and write data.
REQ-011 SHALL have ports busy and done, outputs, 1 each: transaction in flight; one-cycle completion pulse.
REQ-012 SHALL have ports inst_out and mem_out, outputs, DATA_W each: registered read results.
REQ-013 SHALL have port addr_err, output, 1: sticky error flag, present only with MEM_ALIGN_CHECK_EN.

Function
REQ-014 SHALL compute the byte address from mem_dst: 000 pc; 001 imm; 010 mary; 011 shelley; 100 sp+SP_OFFSET; 101 (imm<<2)+sp.
REQ-015 SHALL truncate all address sums to DATA_W bits with wrap-around and no carry out.
REQ-016 SHALL form the word index from byte-address bits [log2(DEPTH):1], so addresses beyond DEPTH words alias modulo DEPTH.
REQ-017 SHALL implement a FSM IDLE -> ACCESS -> DONE -> IDLE.
REQ-018 SHALL, on start=1 in IDLE, latch the address, mem_write, inst_capture and wdata, then enter ACCESS.
REQ-019 SHALL stay in ACCESS for WAIT_STATES+1 cycles, counted by a down-counter.
REQ-020 SHALL perform the array read or write on the last ACCESS cycle.
REQ-021 SHALL, in DONE, assert done for exactly one cycle and update inst_out or mem_out for a read; both outputs hold on a write.
REQ-022 SHALL give read latency = WAIT_STATES+2 cycles from the start sample edge to done high.
REQ-023 SHALL assert busy in ACCESS and DONE.
REQ-024 SHALL ignore start while busy=1; back-to-back start is accepted in the cycle after done.
REQ-025 SHALL ignore input changes after latch; the latched values govern the whole transaction.
REQ-026 SHALL treat reserved mem_dst codes 110 and 111 as a no-op: no write, outputs hold, done still pulses.
REQ-027 SHALL make a read issued after a completed write to the same word return the new data.

Reset
REQ-028 SHALL, on reset=1, force IDLE, clear the counter and set busy=0, done=0, inst_out=0, mem_out=0 and addr_err=0.
REQ-029 SHALL, on reset during ACCESS, abort the transaction with no array write; memory contents are not cleared by reset.

Configuration
REQ-030 SHALL, with macro MEM_ALIGN_CHECK_EN defined, set addr_err when a latched address has bit0=1, and that transaction SHALL skip the write or read while done still pulses.
REQ-031 SHALL, without MEM_ALIGN_CHECK_EN, have no addr_err port and ignore address bit0.

Structure
REQ-032 SHALL take the mem_dst encodings and the FSM state type from shared package mem_pkg.
REQ-033 SHALL use one sub-module, mem_array (DEPTH x DATA_W synchronous single-port RAM), as the only storage.

Verification
REQ-034 SHALL cover: WAIT_STATES=1, write mem_dst=010, mary=0x0010, wdata=0xBEEF, then read the same address -> mem_out=0xBEEF, done 3 cycles after start.
REQ-035 SHALL cover: sp=0xFFFF, mem_dst=100 -> address wraps to 0x0001 (with EN: addr_err=1, no access); sp=0xFFFE -> address 0x0000.
REQ-036 SHALL cover: mem_dst=101, imm=0x0003, sp=0x0100 -> word at byte 0x010C accessed; inst_capture=1 -> only inst_out changes.
REQ-037 SHALL cover: start pulsed every cycle -> exactly one transaction per IDLE entry; extra starts are dropped.
REQ-038 SHALL cover: reset asserted mid-ACCESS on a write to 0x0020 -> later read of 0x0020 returns the prior value and all outputs are 0 after reset.
REQ-039 SHALL cover: mem_dst=111 -> done pulses, no write, mem_out unchanged.
